fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the RV32I 5-stage pipeline.
//  Holds the PC and issues single-outstanding requests to instruction memory.
//  Captures each returned word into IF/ID. Holds IF/ID while the decode interlock
//  asserts stall; flushes and refetches on a branch/jump redirect from EXE.
//  Drives the opcode/rs1/rs2 fields consumed by control_interlock.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset; bits [1:0] must be 0
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   synchronous, active-low reset (0 = reset)
//  stall            in   1   decode interlock: hold IF/ID contents this cycle
//  redirect_valid   in   1   EXE taken branch/JAL/JALR: flush and refetch
//  redirect_pc      in   32  new fetch target; bits [1:0] ignored (treated as 0)
//  imem_req         out  1   request pulse; the address is accepted in the same cycle
//  imem_addr        out  32  word address of the request (= pc)
//  imem_rvalid      in   1   response valid; arrives >=1 cycle after the request
//  imem_rdata       in   32  instruction word; qualified by imem_rvalid
//  if_id_valid      out  1   IF/ID holds a live instruction
//  if_id_pc         out  32  PC of the IF/ID instruction
//  if_id_instr      out  32  instruction word; 32'h0 whenever if_id_valid=0
//  if_id_opcode     out  7   if_id_instr[6:0]
//  if_id_read_reg1  out  5   if_id_instr[19:15]
//  if_id_read_reg2  out  5   if_id_instr[24:20]
//  if_id_write_reg  out  5   if_id_instr[11:7]
// BEHAVIOUR
//  - Reset (reset=0 at an edge): state=IDLE, pc=RESET_PC, if_id_valid=0.
//    After reset, if_id_pc=0 and if_id_instr=0, so all field outputs are 0.
//    imem_req=0 while reset=0. Memory shares this reset, so in-flight responses die with it.
//  - FSM states:
//    - IDLE: imem_req = ~redirect_valid. Without redirect, go to WAIT.
//    - WAIT: request outstanding. On imem_rvalid, load IF/ID with {pc, imem_rdata},
//      set pc <= pc+4 (mod 2^32) and go to FULL. The word is captured even if stall=1.
//    - FULL: if_id_valid=1. If stall=0, the instruction is consumed at this edge and
//      imem_req=1 (addr=pc) in the same cycle; if_id_valid<=0, go to WAIT.
//      If stall=1, hold everything, imem_req=0, stay in FULL.
//    - DRAIN: one response is still outstanding for a squashed fetch. The next
//      imem_rvalid is discarded, then go to IDLE. imem_req=0.
//  - Redirect priority is highest; stall is ignored in any cycle where redirect_valid=1:
//    - pc <= {redirect_pc[31:2],2'b00}, if_id_valid <= 0, instr <= 0.
//    - From IDLE or FULL: go to IDLE; imem_req is suppressed that cycle.
//    - From WAIT with imem_rvalid=0: go to DRAIN.
//    - From WAIT with imem_rvalid=1 in the same cycle: drop the word, go to IDLE.
//    - From DRAIN: stay in DRAIN with the new pc.
//  - imem_rvalid is ignored in IDLE/FULL; at most one request is outstanding.
//  - Latency: redirect -> imem_req of the target = 1 cycle. rvalid -> if_id_valid = 1 cycle.
//  - All IF/ID outputs are registered; imem_req/imem_addr are combinational from state/inputs.
// TESTING
//  1. Reset release, RESET_PC=0x100, memory latency 1:
//     -> requests to 0x100, 0x104, 0x108; if_id_pc follows the same sequence.
//  2. stall=1 for 3 cycles while FULL with instr 0x00500093:
//     -> if_id_* stable, no imem_req; next fetch issues on the cycle stall drops.
//  3. redirect_valid with redirect_pc=0x203 while WAIT (latency 3):
//     -> the old response is dropped, if_id_valid stays 0, next request addr=0x200.
//  4. redirect_valid and imem_rvalid in the same WAIT cycle:
//     -> no IF/ID load; next cycle imem_req with addr = redirect target.
//  5. stall=1 and redirect_valid=1 in FULL:
//     -> flush wins; if_id_valid=0 and if_id_opcode=0 the next cycle.
//  6. reset=0 asserted mid-WAIT, and pc=0xFFFF_FFFC fetch:
//     -> reset returns IDLE/RESET_PC; in the wrap case the next pc is 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32I 5-stage pipeline.
// Keeps at most one request outstanding to instruction memory; EXE redirects flush IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  if_id_opcode,
  output logic [4:0]  if_id_read_reg1,
  output logic [4:0]  if_id_read_reg2,
  output logic [4:0]  if_id_write_reg
);

  typedef enum logic [1:0] {StIdle, StWait, StFull, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req;

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      ifid_pc_q <= 32'h0;
      instr_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      ifid_pc_q <= ifid_pc_d;
      instr_q   <= instr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    ifid_pc_d = ifid_pc_q;
    instr_d   = instr_q;
    req       = 1'b0;

    if (redirect_valid) begin
      // Flush wins over stall; a request still in flight must be drained first.
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      instr_d = 32'h0;
      unique case (state_q)
        StWait:  state_d = imem_rvalid ? StIdle : StDrain;
        StDrain: state_d = StDrain;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          req     = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            ifid_pc_d = pc_q;
            instr_d   = imem_rdata;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
            state_d   = StFull;
          end
        end
        StFull: begin
          if (!stall) begin
            req     = 1'b1;
            valid_d = 1'b0;
            instr_d = 32'h0;
            state_d = StWait;
          end
        end
        StDrain: begin
          if (imem_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign imem_req        = req & reset;
  assign imem_addr       = pc_q;
  assign if_id_valid     = valid_q;
  assign if_id_pc        = ifid_pc_q;
  assign if_id_instr     = instr_q;
  assign if_id_opcode    = instr_q[6:0];
  assign if_id_read_reg1 = instr_q[19:15];
  assign if_id_read_reg2 = instr_q[24:20];
  assign if_id_write_reg = instr_q[11:7];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model answers requests,
// expected request addresses and IF/ID entries are queued by the stimulus and popped on output.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_opcode;
  logic [4:0]  if_id_read_reg1;
  logic [4:0]  if_id_read_reg2;
  logic [4:0]  if_id_write_reg;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_opcode    (if_id_opcode),
    .if_id_read_reg1 (if_id_read_reg1),
    .if_id_read_reg2 (if_id_read_reg2),
    .if_id_write_reg (if_id_write_reg)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  logic [31:0] exp_addr_q[$];
  ifid_t       exp_ifid_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0108) return 32'h0050_0093;
    return a ^ 32'h5A3C_9E71;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic push_ifid(input logic [31:0] pc);
    ifid_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_ifid_q.push_back(e);
  endtask

  // Memory: samples the request late in the cycle, answers `lat` cycles later.
  initial begin
    logic        s_req, s_rst, s_rv, pending;
    logic [31:0] s_addr, paddr;
    int          cnt;
    pending     = 1'b0;
    paddr       = 32'h0;
    cnt         = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clock);
      #4;
      s_req  = imem_req;
      s_addr = imem_addr;
      s_rst  = reset;
      s_rv   = imem_rvalid;
      @(posedge clock);
      #1;
      if (!s_rst) begin
        pending = 1'b0;
      end else begin
        if (s_rv) pending = 1'b0;
        if (s_req) begin
          pending = 1'b1;
          paddr   = s_addr;
          cnt     = lat;
        end
      end
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
        end
      end
    end
  end

  // Output monitor: every request and every new IF/ID entry is matched against the queues.
  initial begin
    logic  prev_valid;
    ifid_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      #3;
      if (reset) begin
        if (imem_req) begin
          check_eq("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) check_eq("req_addr", imem_addr, exp_addr_q.pop_front());
        end
        if (if_id_valid && !prev_valid) begin
          check_eq("ifid_expected", 32'(exp_ifid_q.size() != 0), 32'd1);
          if (exp_ifid_q.size() != 0) begin
            e = exp_ifid_q.pop_front();
            check_eq("ifid_pc", if_id_pc, e.pc);
            check_eq("ifid_instr", if_id_instr, e.instr);
            check_eq("ifid_opcode", 32'(if_id_opcode), 32'(e.instr[6:0]));
            check_eq("ifid_rs1", 32'(if_id_read_reg1), 32'(e.instr[19:15]));
            check_eq("ifid_rs2", 32'(if_id_read_reg2), 32'(e.instr[24:20]));
            check_eq("ifid_rd", 32'(if_id_write_reg), 32'(e.instr[11:7]));
          end
        end
        if (!if_id_valid) check_eq("instr_zero_when_invalid", if_id_instr, 32'h0);
        prev_valid = if_id_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic wait_ifid(input string tag, input logic [31:0] pc);
    logic found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (if_id_valid && if_id_pc == pc) found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (imem_req) found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_rvalid(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (imem_rvalid) found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h100);
    check_eq("rst_valid", 32'(if_id_valid), 32'd0);
    check_eq("rst_pc", if_id_pc, 32'h0);
    check_eq("rst_instr", if_id_instr, 32'h0);

    // 1: sequential fetch from RESET_PC, latency 1
    @(negedge clock);
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h108);
    push_ifid(32'h100);
    push_ifid(32'h104);
    push_ifid(32'h108);
    reset = 1'b1;
    wait_ifid("t1_reach_108", 32'h108);
    stall = 1'b1;

    // 2: stall holds IF/ID for 3 cycles, fetch resumes as stall drops
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("t2_hold_pc", if_id_pc, 32'h108);
      check_eq("t2_hold_instr", if_id_instr, 32'h0050_0093);
      check_eq("t2_hold_valid", 32'(if_id_valid), 32'd1);
      check_eq("t2_no_req", 32'(imem_req), 32'd0);
    end
    lat = 3;
    exp_addr_q.push_back(32'h10C);
    stall = 1'b0;
    #1;
    check_eq("t2_req_on_release", 32'(imem_req), 32'd1);
    check_eq("t2_addr_on_release", imem_addr, 32'h10C);

    // 3: redirect while WAIT (latency 3): stale response is drained and dropped
    @(negedge clock);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clock);
    redirect_valid = 1'b0;
    exp_addr_q.push_back(32'h200);
    wait_req("t3_req_after_drain");
    check_eq("t3_addr", imem_addr, 32'h200);
    check_eq("t3_valid_low", 32'(if_id_valid), 32'd0);

    // 4: redirect in the same cycle as the response
    wait_rvalid("t4_rvalid");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    exp_addr_q.push_back(32'h300);
    @(negedge clock);
    redirect_valid = 1'b0;
    lat            = 1;
    push_ifid(32'h300);
    #1;
    check_eq("t4_req", 32'(imem_req), 32'd1);
    check_eq("t4_addr", imem_addr, 32'h300);
    check_eq("t4_no_load", 32'(if_id_valid), 32'd0);

    // 5: stall and redirect together in FULL: flush wins
    wait_ifid("t5_reach_300", 32'h300);
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    #1;
    check_eq("t5_req_suppressed", 32'(imem_req), 32'd0);
    @(negedge clock);
    check_eq("t5_valid", 32'(if_id_valid), 32'd0);
    check_eq("t5_opcode", 32'(if_id_opcode), 32'd0);
    lat = 3;
    exp_addr_q.push_back(32'h400);
    stall          = 1'b0;
    redirect_valid = 1'b0;

    // 6a: reset mid-WAIT
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("t6_req_in_reset", 32'(imem_req), 32'd0);
    @(negedge clock);
    @(negedge clock);
    check_eq("t6_rst_addr", imem_addr, 32'h100);
    check_eq("t6_rst_valid", 32'(if_id_valid), 32'd0);
    check_eq("t6_rst_pc", if_id_pc, 32'h0);
    lat = 1;
    exp_addr_q.push_back(32'h100);
    push_ifid(32'h100);
    reset = 1'b1;
    wait_ifid("t6_reach_100", 32'h100);

    // 6b: pc wraps past 0xFFFF_FFFC
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    push_ifid(32'hFFFF_FFFC);
    @(negedge clock);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    wait_ifid("t6_reach_top", 32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    push_ifid(32'h0);
    check_eq("t6_wrap_addr", imem_addr, 32'h0);
    wait_ifid("t6_reach_zero", 32'h0);
    stall = 1'b1;

    repeat (3) @(negedge clock);
    check_eq("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check_eq("ifid_queue_drained", 32'(exp_ifid_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
